// File: rtl/debounce_scheduler.sv
// Multi-switch debouncer that time-shares one settle counter across all inputs.
// A round-robin scheduler grants the counter to one pending switch at a time.
module debounce_scheduler #(
  parameter int unsigned NUM_SW = 4,
  parameter int unsigned LIMIT  = 250000,
  parameter int unsigned CNT_W  = 18,
  localparam int unsigned GW    = (NUM_SW > 1) ? $clog2(NUM_SW) : 1
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic [NUM_SW-1:0] i_Switch,
  output logic [NUM_SW-1:0] o_Switch,
  output logic [NUM_SW-1:0] o_Press,
  output logic [NUM_SW-1:0] o_Release,
  output logic              o_Busy,
  output logic [GW-1:0]     o_Grant
);

  typedef enum logic {IDLE, COUNT} state_e;

  state_e            state_q;
  logic [NUM_SW-1:0] meta_q, sync_q;
  logic [NUM_SW-1:0] sw_q, press_q, rel_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [GW-1:0]     ptr_q, grant_q;

  logic [NUM_SW-1:0] pending;
  logic              pick_found;
  logic [GW-1:0]     pick_idx, cand_idx;
  int unsigned       cand;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= i_Switch;
      sync_q <= meta_q;
    end
  end

  assign pending = sync_q ^ sw_q;

  // Scan starts one past the last owner so a just-served bit has lowest priority.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int unsigned i = 1; i <= NUM_SW; i++) begin
      cand     = (32'(ptr_q) + i) % NUM_SW;
      cand_idx = GW'(cand);
      if (!pick_found && pending[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= GW'(NUM_SW - 1);
      grant_q <= '0;
      sw_q    <= '0;
      press_q <= '0;
      rel_q   <= '0;
    end else begin
      press_q <= '0;
      rel_q   <= '0;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_q <= pick_idx;
            cnt_q   <= '0;
            state_q <= COUNT;
          end
        end
        COUNT: begin
          if (sync_q[grant_q] == sw_q[grant_q]) begin
            cnt_q   <= '0;
            ptr_q   <= grant_q;
            state_q <= IDLE;
          end else if (cnt_q == CNT_W'(LIMIT - 1)) begin
            sw_q[grant_q] <= sync_q[grant_q];
            if (sync_q[grant_q]) press_q[grant_q] <= 1'b1;
            else                 rel_q[grant_q]   <= 1'b1;
            cnt_q   <= '0;
            ptr_q   <= grant_q;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_Switch  = sw_q;
  assign o_Press   = press_q;
  assign o_Release = rel_q;
  assign o_Busy    = (state_q == COUNT);
  assign o_Grant   = grant_q;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Scoreboard bench for debounce_scheduler: a time-based reference model predicts
// commit pulses and debounced levels; a negedge monitor compares against the DUT.
module tb_debounce_scheduler;

  localparam int N = 4;
  localparam int L = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw_in = '0;
  logic [3:0] o_Switch, o_Press, o_Release;
  logic       o_Busy;
  logic [1:0] o_Grant;

  debounce_scheduler #(.NUM_SW(4), .LIMIT(8), .CNT_W(4)) dut (
    .i_Clk     (clk),
    .i_Rst_L   (rst_n),
    .i_Switch  (sw_in),
    .o_Switch  (o_Switch),
    .o_Press   (o_Press),
    .o_Release (o_Release),
    .o_Busy    (o_Busy),
    .o_Grant   (o_Grant)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct packed {logic [3:0] p; logic [3:0] r;} ev_t;
  ev_t q[$];

  // Reference model: synchronizer is a two-sample delay; a window opened at
  // cycle t commits at cycle t+L unless the synced level returns first.
  logic [3:0] d1 = '0, d2 = '0, m_deb = '0;
  bit         m_open = 0;
  int         m_owner = 0, m_last = N - 1;
  longint     cyc = 0, w_start = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    logic [3:0] s, pend;
    bit found;
    int idx;
    ev_t e;
    if (!rst_n) begin
      d1 = '0; d2 = '0; m_deb = '0; m_open = 0;
      m_owner = 0; m_last = N - 1; cyc = 0; q.delete();
    end else begin
      cyc++;
      s  = d2;
      d2 = d1;
      d1 = sw_in;
      if (!m_open) begin
        pend = s ^ m_deb;
        found = 0;
        for (int i = 1; i <= N; i++) begin
          idx = (m_last + i) % N;
          if (!found && pend[idx]) begin
            found = 1; m_owner = idx;
          end
        end
        if (found) begin
          m_open = 1; w_start = cyc;
        end
      end else if (s[m_owner] == m_deb[m_owner]) begin
        m_open = 0; m_last = m_owner;
      end else if (cyc == w_start + L) begin
        m_deb[m_owner] = s[m_owner];
        e.p = '0; e.r = '0;
        if (s[m_owner]) e.p[m_owner] = 1'b1;
        else            e.r[m_owner] = 1'b1;
        q.push_back(e);
        m_open = 0; m_last = m_owner;
      end
    end
  end

  always @(negedge clk) begin : monitor
    ev_t e;
    if ((o_Press | o_Release) != 4'b0) begin
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL pulse_unexpected: got press=%b release=%b expected none at %0t",
                 o_Press, o_Release, $time);
      end else begin
        e = q.pop_front();
        chk("pulse", {24'b0, o_Press, o_Release}, {24'b0, e.p, e.r});
      end
    end
    if (q.size() != 0) begin
      tests++; fails++;
      $display("FAIL pulse_missing: got none expected press=%b release=%b at %0t",
               q[0].p, q[0].r, $time);
      q.delete();
    end
    chk("switch", {28'b0, o_Switch}, {28'b0, m_deb});
    chk("busy", {31'b0, o_Busy}, {31'b0, m_open});
    if (m_open) chk("grant", {30'b0, o_Grant}, 32'(m_owner));
  end

  task automatic do_reset();
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("reset_outputs", {17'b0, o_Switch, o_Press, o_Release, o_Busy, o_Grant}, 32'b0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  int pe[$];
  int pi[$];
  int rel_cnt, prs_cnt, p;

  task automatic collect_presses(input int n);
    pe.delete(); pi.delete();
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      for (int b = 0; b < N; b++)
        if (o_Press[b]) begin pe.push_back(k); pi.push_back(b); end
    end
  endtask

  initial begin
    sw_in = '0;
    #1;
    chk("reset_at_start", {17'b0, o_Switch, o_Press, o_Release, o_Busy, o_Grant}, 32'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // clean press, commit on edge 11
    sw_in = 4'b0001;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      chk("press_latency_level", {31'b0, o_Switch[0]}, {31'b0, (k >= 11)});
      if (k == 11) chk("press_pulse", {28'b0, o_Press}, 32'h1);
    end

    // bounce on bit 1
    @(negedge clk); sw_in[1] = 1'b1;
    repeat (4) @(negedge clk);
    sw_in[1] = 1'b0;
    repeat (20) @(negedge clk);
    chk("bounce_level", {31'b0, o_Switch[1]}, 32'b0);
    chk("bounce_idle", {31'b0, o_Busy}, 32'b0);

    // simultaneous press
    do_reset();
    sw_in = 4'b1111;
    collect_presses(45);
    chk("simul_count", 32'(pe.size()), 32'd4);
    for (int i = 0; i < 4 && i < pe.size(); i++) begin
      chk("simul_order", 32'(pi[i]), 32'(i));
      chk("simul_edge", 32'(pe[i]), 32'(11 + 9 * i));
    end

    // round-robin after bit 2
    do_reset();
    sw_in = 4'b0100;
    repeat (4) @(negedge clk);
    sw_in = 4'b1110;
    collect_presses(40);
    chk("rr_count", 32'(pe.size()), 32'd3);
    if (pe.size() == 3) begin
      chk("rr_first", 32'(pi[0]), 32'd2);
      chk("rr_second", 32'(pi[1]), 32'd3);
      chk("rr_third", 32'(pi[2]), 32'd1);
    end

    // release of bit 0
    do_reset();
    sw_in = 4'b0001;
    repeat (15) @(negedge clk);
    sw_in = 4'b0000;
    rel_cnt = 0; prs_cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      rel_cnt += int'(o_Release[0]);
      prs_cnt += int'(o_Press != 4'b0);
    end
    chk("release_pulses", 32'(rel_cnt), 32'd1);
    chk("release_no_press", 32'(prs_cnt), 32'd0);
    chk("release_level", {28'b0, o_Switch}, 32'b0);

    // reset mid-COUNT (counter at 5), then full re-debounce
    do_reset();
    sw_in = 4'b0100;
    repeat (8) @(posedge clk);
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      chk("redebounce_level", {31'b0, o_Switch[2]}, {31'b0, (k >= 11)});
    end

    // randomized bouncing with varying activity
    for (int ep = 0; ep < 60; ep++) begin
      case ($urandom_range(0, 2))
        0:       p = 1;
        1:       p = 8;
        default: p = 30;
      endcase
      if (ep == 30) do_reset();
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        for (int b = 0; b < N; b++)
          if ($urandom_range(0, 99) < p) sw_in[b] = ~sw_in[b];
      end
    end
    repeat (60) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/debounce_scheduler.md
DEBOUNCE_SCHEDULER -- requirements
Module: debounce_scheduler

Interface
REQ-001 Parameters SHALL be: NUM_SW, default 4, number of switch inputs; LIMIT, default 250000, settle cycles (>=2); CNT_W, default 18, counter width (2^CNT_W > LIMIT-1).
REQ-002 Port i_Clk  input  1  sole clock; all state SHALL change on the rising edge only.
REQ-003 Port i_Rst_L  input  1  asynchronous, active-low reset.
REQ-004 Port i_Switch  input  NUM_SW  raw, asynchronous, bouncing switch levels.
REQ-005 Port o_Switch  output  NUM_SW  debounced switch levels, registered.
REQ-006 Port o_Press  output  NUM_SW  one-cycle pulse per bit on a debounced 0->1 commit.
REQ-007 Port o_Release  output  NUM_SW  one-cycle pulse per bit on a debounced 1->0 commit.
REQ-008 Port o_Busy  output  1  high while the shared settle counter is allocated (state COUNT).
REQ-009 Port o_Grant  output  clog2(NUM_SW)  index currently or most recently owning the counter.

Function
REQ-010 Each i_Switch bit SHALL pass through a 2-flop synchronizer; "sync[k]" denotes the second flop.
REQ-011 One CNT_W-bit settle counter SHALL be shared by all inputs; no per-input counters.
REQ-012 Bit k is "pending" when sync[k] != o_Switch[k].
REQ-013 FSM states SHALL be IDLE and COUNT only.
REQ-014 IDLE: if any bit is pending, select g by round-robin, starting at ptr+1 and wrapping modulo NUM_SW; set o_Grant=g, counter=0, go to COUNT; otherwise stay in IDLE.
REQ-015 COUNT, sync[g]==o_Switch[g] (bounce back): abort; counter=0, ptr=g, go to IDLE; o_Switch unchanged; no pulse.
REQ-016 COUNT, still pending and counter==LIMIT-1: commit; o_Switch[g]<=sync[g], counter=0, ptr=g, go to IDLE.
REQ-017 COUNT, otherwise: counter increments by 1.
REQ-018 Commit latency SHALL be exactly LIMIT+1 edges after the edge on which sync[g] first mismatches while in IDLE with g selected.
REQ-019 o_Press[g] / o_Release[g] SHALL be high for exactly the one cycle following the commit edge (coincident with the new o_Switch value); at most one bit of o_Press|o_Release is high in any cycle.
REQ-020 Pending bits other than g SHALL wait untouched; a waiting bit that returns to its debounced level before being granted SHALL generate no activity.
REQ-021 Fairness: a continuously pending bit SHALL be granted within NUM_SW-1 completed COUNT windows.
REQ-022 The counter SHALL never exceed LIMIT-1 and SHALL never wrap.
REQ-023 o_Busy SHALL equal (state==COUNT); the minimum IDLE dwell between windows SHALL be one cycle.

Reset
REQ-024 While i_Rst_L=0: o_Switch=0, o_Press=0, o_Release=0, o_Busy=0, o_Grant=0, counter=0, synchronizers=0, state=IDLE, ptr=NUM_SW-1 (so bit 0 has first priority).
REQ-025 Reset assertion mid-COUNT SHALL abandon the window immediately with no commit and no pulse.
REQ-026 After release, the first grant SHALL be no earlier than the third rising edge (synchronizer fill).

Verification (LIMIT=8, NUM_SW=4)
REQ-027 Clean press: i_Switch[0] 0->1 and held -> o_Switch[0] rises on the 11th rising edge counting the first sampling edge as edge 1; o_Press[0]=1 for exactly that cycle; o_Busy high for 8 cycles.
REQ-028 Bounce: i_Switch[1] high for 4 cycles, then low -> abort; o_Switch[1] stays 0; no o_Press; state returns to IDLE.
REQ-029 Simultaneous: bits 0..3 all rise on one edge -> commits in order 0,1,2,3; each separated by 9 cycles (8 COUNT + 1 IDLE); four single-cycle o_Press pulses.
REQ-030 Round-robin: after bit 2 commits, bits 1 and 3 both pending -> bit 3 is granted first.
REQ-031 Release: o_Switch[0]=1, i_Switch[0] 1->0 held -> o_Switch[0] falls with a one-cycle o_Release[0]; no o_Press.
REQ-032 Reset mid-COUNT: i_Rst_L low at counter=5 -> all outputs 0 asynchronously; after release, a still-high input re-debounces from counter=0 with full latency.
